// File: rtl/prim_opgate_idle.sv
// Multi-channel operand-isolation stage with automatic idle gating.
// Each channel is an independent GATED -> WAKE -> ACTIVE machine fronting a
// single-entry registered valid/ready stage. Idle channels fall back to
// GATED so the downstream datapath (multiplier, shifter, ...) sees no toggling.
module prim_opgate_idle #(
  parameter int    DATA_WIDTH  = 1,
  parameter int    NUM_CH      = 1,
  parameter string MODE        = "ZERO",
  parameter int    IDLE_CYCLES = 4,
  parameter int    WAKE_CYCLES = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_CH-1:0]            en_i,
  input  logic [NUM_CH-1:0]            valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  output logic [NUM_CH-1:0]            ready_o,
  output logic [NUM_CH-1:0]            valid_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_o,
  output logic [NUM_CH-1:0]            gated_o
);

  // Widths are clamped so an illegal parameter still elaborates far enough
  // for the $error below to be reported instead of a zero-width vector.
  localparam int IDLE_W = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam int WAKE_W = (WAKE_CYCLES < 1) ? 1 : $clog2(WAKE_CYCLES + 1);

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_INIT = WAKE_W'(WAKE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [WAKE_W-1:0] WAKE_ONE  = WAKE_W'(1);

  localparam bit MODE_HOLD = (MODE == "HOLD");
  localparam bit MODE_ZERO = (MODE == "ZERO");

  if (!MODE_HOLD && !MODE_ZERO) begin : g_bad_mode
    $error("prim_opgate_idle: MODE must be \"ZERO\" or \"HOLD\"");
  end
  if (IDLE_CYCLES < 1) begin : g_bad_idle
    $error("prim_opgate_idle: IDLE_CYCLES must be >= 1");
  end
  if (WAKE_CYCLES < 1) begin : g_bad_wake
    $error("prim_opgate_idle: WAKE_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_GATED  = 2'd0,
    ST_WAKE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e                  r_state;
    logic [IDLE_W-1:0]       r_idle_cnt;
    logic [WAKE_W-1:0]       r_wake_cnt;
    logic [DATA_WIDTH-1:0]   r_data_q;
    logic                    r_valid_q;

    logic                    w_en;
    logic                    w_valid;
    logic                    w_ready;
    logic                    w_xfer;
    logic [DATA_WIDTH-1:0]   w_data;

    assign w_en    = en_i[c];
    assign w_valid = valid_i[c];
    assign w_data  = data_i[c*DATA_WIDTH +: DATA_WIDTH];

    // Ready depends only on state and permit, never on valid, so upstream
    // may legally wait for ready before raising valid.
    assign w_ready = (r_state == ST_ACTIVE) && w_en;
    assign w_xfer  = w_valid && w_ready;

    // Channel FSM, idle/wake counters and the single-entry operand register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours; r_data_q is an ordinary
    // register (not a memory) and is reset so HOLD mode starts from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state    <= ST_GATED;
        r_idle_cnt <= '0;
        r_wake_cnt <= '0;
        r_data_q   <= '0;
        r_valid_q  <= 1'b0;
      end else begin
        // The output pulse marks the transfer of the previous cycle, even if
        // the channel is leaving ACTIVE on this edge.
        r_valid_q <= w_xfer;
        if (w_xfer) begin
          r_data_q <= w_data;
        end

        unique case (r_state)
          ST_GATED: begin
            // The operand that triggers wake-up is not consumed; upstream
            // keeps valid asserted until the channel becomes ready.
            if (w_en && w_valid) begin
              r_state    <= ST_WAKE;
              r_wake_cnt <= WAKE_INIT;
            end
          end

          ST_WAKE: begin
            if (!w_en) begin
              r_state    <= ST_GATED;
              r_wake_cnt <= '0;
            end else if (r_wake_cnt == WAKE_ONE) begin
              r_state    <= ST_ACTIVE;
              r_wake_cnt <= '0;
              r_idle_cnt <= '0;
            end else begin
              r_wake_cnt <= r_wake_cnt - WAKE_ONE;
            end
          end

          ST_ACTIVE: begin
            if (!w_en) begin
              r_state    <= ST_GATED;
              r_idle_cnt <= '0;
            end else if (w_xfer) begin
              r_idle_cnt <= '0;
            end else if (r_idle_cnt == IDLE_LAST) begin
              // Last permitted idle cycle; the counter never wraps.
              r_state    <= ST_GATED;
              r_idle_cnt <= '0;
            end else begin
              r_idle_cnt <= r_idle_cnt + IDLE_ONE;
            end
          end

          default: begin
            r_state    <= ST_GATED;
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
          end
        endcase
      end
    end

    assign ready_o[c] = w_ready;
    assign valid_o[c] = r_valid_q;
    assign gated_o[c] = (r_state == ST_GATED);

    if (MODE_HOLD) begin : g_hold
      assign data_o[c*DATA_WIDTH +: DATA_WIDTH] = r_data_q;
    end else begin : g_zero
      assign data_o[c*DATA_WIDTH +: DATA_WIDTH] = r_valid_q ? r_data_q : '0;
    end
  end

endmodule

// File: tb/tb_prim_opgate_idle.sv
// Directed bench for prim_opgate_idle: a ZERO and a HOLD instance share the
// same stimulus; accepted operands go into per-channel queues and are popped
// when the matching output pulse is due.
module tb_prim_opgate_idle;
  localparam int DW = 8;
  localparam int NC = 2;
  localparam int IC = 4;
  localparam int WC = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC-1:0]   en;
  logic [NC-1:0]   valid;
  logic [NC*DW-1:0] din;

  logic [NC-1:0]    rdy_z, vo_z, gt_z;
  logic [NC*DW-1:0] dout_z;
  logic [NC-1:0]    rdy_h, vo_h, gt_h;
  logic [NC*DW-1:0] dout_h;

  always #5 clk = ~clk;

  prim_opgate_idle #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .MODE("ZERO"),
    .IDLE_CYCLES(IC), .WAKE_CYCLES(WC)
  ) u_dut_zero (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .valid_i(valid), .data_i(din),
    .ready_o(rdy_z), .valid_o(vo_z), .data_o(dout_z), .gated_o(gt_z)
  );

  prim_opgate_idle #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .MODE("HOLD"),
    .IDLE_CYCLES(IC), .WAKE_CYCLES(WC)
  ) u_dut_hold (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .valid_i(valid), .data_i(din),
    .ready_o(rdy_h), .valid_o(vo_h), .data_o(dout_h), .gated_o(gt_h)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [NC-1:0] exp_vo;
  logic [DW-1:0] hold0, hold1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string step);
    chk({step, ".ready_z"}, 16'(rdy_z), 16'h0);
    chk({step, ".ready_h"}, 16'(rdy_h), 16'h0);
    chk({step, ".gated_z"}, 16'(gt_z), 16'h3);
    chk({step, ".gated_h"}, 16'(gt_h), 16'h3);
    chk({step, ".valid_z"}, 16'(vo_z), 16'h0);
    chk({step, ".valid_h"}, 16'(vo_h), 16'h0);
    chk({step, ".data_z"}, dout_z, 16'h0);
    chk({step, ".data_h"}, dout_h, 16'h0);
  endtask

  // One clock cycle: drive inputs just after the edge, check at the falling
  // edge, then record which operands the bench expects to be accepted.
  task automatic cyc(input string step, input logic [1:0] e, input logic [1:0] v,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input logic [1:0] x_rdy, input logic [1:0] x_gated);
    logic [DW-1:0] e0, e1;
    en    = e;
    valid = v;
    din   = {d1, d0};
    #4;
    e0 = '0;
    e1 = '0;
    if (exp_vo[0] && q0.size() != 0) begin
      e0    = q0.pop_front();
      hold0 = e0;
    end
    if (exp_vo[1] && q1.size() != 0) begin
      e1    = q1.pop_front();
      hold1 = e1;
    end
    chk({step, ".ready_z"}, 16'(rdy_z), 16'(x_rdy));
    chk({step, ".ready_h"}, 16'(rdy_h), 16'(x_rdy));
    chk({step, ".gated_z"}, 16'(gt_z), 16'(x_gated));
    chk({step, ".gated_h"}, 16'(gt_h), 16'(x_gated));
    chk({step, ".valid_z"}, 16'(vo_z), 16'(exp_vo));
    chk({step, ".valid_h"}, 16'(vo_h), 16'(exp_vo));
    chk({step, ".data_z"}, dout_z, {e1, e0});
    chk({step, ".data_h"}, dout_h, {hold1, hold0});
    exp_vo = x_rdy & v;
    if (exp_vo[0]) q0.push_back(d0);
    if (exp_vo[1]) q1.push_back(d1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    en     = '0;
    valid  = '0;
    din    = '0;
    exp_vo = '0;
    hold0  = '0;
    hold1  = '0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Cold start on ch0: two WAKE cycles, accept on the third cycle.
    cyc("c01", 2'b01, 2'b01, 8'hA5, 8'h00, 2'b00, 2'b11);
    cyc("c02", 2'b01, 2'b01, 8'hA5, 8'h00, 2'b00, 2'b10);
    cyc("c03", 2'b01, 2'b01, 8'hA5, 8'h00, 2'b00, 2'b10);
    cyc("c04", 2'b01, 2'b01, 8'hA5, 8'h00, 2'b01, 2'b10);
    // Four idle cycles in ACTIVE, then GATED.
    cyc("c05", 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 2'b10);
    cyc("c06", 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 2'b10);
    cyc("c07", 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 2'b10);
    cyc("c08", 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 2'b10);
    // Re-wake, transfer 0x3C, then a transfer on the fourth idle cycle.
    cyc("c09", 2'b01, 2'b01, 8'h3C, 8'h00, 2'b00, 2'b11);
    cyc("c10", 2'b01, 2'b01, 8'h3C, 8'h00, 2'b00, 2'b10);
    cyc("c11", 2'b01, 2'b01, 8'h3C, 8'h00, 2'b00, 2'b10);
    cyc("c12", 2'b01, 2'b01, 8'h3C, 8'h00, 2'b01, 2'b10);
    cyc("c13", 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 2'b10);
    cyc("c14", 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 2'b10);
    cyc("c15", 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 2'b10);
    cyc("c16", 2'b01, 2'b01, 8'h5A, 8'h00, 2'b01, 2'b10);
    // Transfer 0x11, then en drops together with a new valid: no transfer.
    cyc("c17", 2'b01, 2'b01, 8'h11, 8'h00, 2'b01, 2'b10);
    cyc("c18", 2'b00, 2'b01, 8'h22, 8'h00, 2'b00, 2'b10);
    cyc("c19", 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11);
    cyc("c20", 2'b01, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11);
    // Both channels wake; ch0 streams while ch1 goes idle and gates.
    cyc("c21", 2'b11, 2'b11, 8'h01, 8'hF0, 2'b00, 2'b11);
    cyc("c22", 2'b11, 2'b11, 8'h01, 8'hF0, 2'b00, 2'b00);
    cyc("c23", 2'b11, 2'b11, 8'h01, 8'hF0, 2'b00, 2'b00);
    cyc("c24", 2'b11, 2'b11, 8'h01, 8'hF0, 2'b11, 2'b00);
    cyc("c25", 2'b11, 2'b01, 8'h02, 8'h00, 2'b11, 2'b00);
    cyc("c26", 2'b11, 2'b01, 8'h03, 8'h00, 2'b11, 2'b00);
    cyc("c27", 2'b11, 2'b01, 8'h04, 8'h00, 2'b11, 2'b00);
    cyc("c28", 2'b11, 2'b01, 8'h05, 8'h00, 2'b11, 2'b00);
    cyc("c29", 2'b11, 2'b01, 8'h06, 8'h00, 2'b01, 2'b10);

    // Asynchronous reset between edges while 0x06 is on the output.
    en    = 2'b11;
    valid = 2'b01;
    din   = {8'h00, 8'h07};
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    q0.delete();
    q1.delete();
    exp_vo = '0;
    hold0  = '0;
    hold1  = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full wake sequence again after reset.
    cyc("r01", 2'b01, 2'b01, 8'h77, 8'h00, 2'b00, 2'b11);
    cyc("r02", 2'b01, 2'b01, 8'h77, 8'h00, 2'b00, 2'b10);
    cyc("r03", 2'b01, 2'b01, 8'h77, 8'h00, 2'b00, 2'b10);
    cyc("r04", 2'b01, 2'b01, 8'h77, 8'h00, 2'b01, 2'b10);
    cyc("r05", 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
